// File: rtl/axil_cmd_master_if.sv
// Command, response and AXI4-Lite signal bundle for axil_cmd_master.
// master = initiator side, slave = controller/responder side.
interface axil_cmd_master_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_wstrb;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_write;
   logic [DATA_W-1:0] rsp_rdata;
   logic [1:0]        rsp_resp;
   logic              busy;

   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr,
      input  cmd_wdata, cmd_wstrb,
      output cmd_ready,
      output rsp_valid, rsp_write, rsp_rdata,
      output rsp_resp, busy,
      input  rsp_ready,
      output awaddr, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr,
      output cmd_wdata, cmd_wstrb,
      input  cmd_ready,
      input  rsp_valid, rsp_write, rsp_rdata,
      input  rsp_resp, busy,
      output rsp_ready,
      input  awaddr, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready
// command port, with a registered response port.
module axil_cmd_master #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   axil_cmd_master_if.master bus
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WB,
      S_RA,
      S_RD,
      S_RSP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic              r_awvalid;
   logic              r_wvalid;
   logic              r_arvalid;
   logic              r_aw_done;
   logic              r_w_done;
   logic              r_rsp_write;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic [1:0]        r_rsp_resp;

   logic w_cmd_hs;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_aw_all;
   logic w_w_all;
   logic w_b_hs;
   logic w_ar_hs;
   logic w_r_hs;
   logic w_rsp_hs;

   // cmd_ready is held low for as long as reset is asserted
   assign bus.cmd_ready = (r_state == S_IDLE) & aresetn;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.bready    = (r_state == S_WB);
   assign bus.rready    = (r_state == S_RD);
   assign bus.rsp_valid = (r_state == S_RSP);
   assign bus.rsp_write = r_rsp_write;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_resp  = r_rsp_resp;
   assign bus.awaddr    = r_addr;
   assign bus.araddr    = r_addr;
   assign bus.awvalid   = r_awvalid;
   assign bus.wvalid    = r_wvalid;
   assign bus.arvalid   = r_arvalid;
   assign bus.wdata     = r_wdata;
   assign bus.wstrb     = r_wstrb;

   assign w_cmd_hs = bus.cmd_valid & bus.cmd_ready;
   assign w_aw_hs  = r_awvalid & bus.awready;
   assign w_w_hs   = r_wvalid & bus.wready;
   assign w_aw_all = r_aw_done | w_aw_hs;
   assign w_w_all  = r_w_done | w_w_hs;
   assign w_b_hs   = bus.bready & bus.bvalid;
   assign w_ar_hs  = r_arvalid & bus.arready;
   assign w_r_hs   = bus.rready & bus.rvalid;
   assign w_rsp_hs = bus.rsp_valid & bus.rsp_ready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_cmd_hs) begin
               w_next = bus.cmd_write ? S_WR : S_RA;
            end
         end
         S_WR: begin
            if (w_aw_all && w_w_all) begin
               w_next = S_WB;
            end
         end
         S_WB: begin
            if (w_b_hs) begin
               w_next = S_RSP;
            end
         end
         S_RA: begin
            if (w_ar_hs) begin
               w_next = S_RD;
            end
         end
         S_RD: begin
            if (w_r_hs) begin
               w_next = S_RSP;
            end
         end
         S_RSP: begin
            if (w_rsp_hs) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
      end else begin
         if (w_cmd_hs) begin
            r_addr      <= bus.cmd_addr;
            r_wdata     <= bus.cmd_write ? bus.cmd_wdata : '0;
            r_wstrb     <= bus.cmd_write ? bus.cmd_wstrb : '0;
            r_awvalid   <= bus.cmd_write;
            r_wvalid    <= bus.cmd_write;
            r_arvalid   <= ~bus.cmd_write;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_write <= bus.cmd_write;
         end
         // AW and W retire independently; either may finish first
         if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
         end
         if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
         end
         if (w_ar_hs) begin
            r_arvalid <= 1'b0;
         end
         if (w_b_hs) begin
            r_rsp_rdata <= '0;
            r_rsp_resp  <= bus.bresp;
         end
         if (w_r_hs) begin
            r_rsp_rdata <= bus.rdata;
            r_rsp_resp  <= bus.rresp;
         end
      end
   end
endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite initiator that turns a simple valid/ready command port into single AXI4-Lite read or write transactions. It sits between a local controller (sequencer, debug bridge, or CPU-less init engine) and AXI4-Lite responders such as axi_gpio. It allows exactly one transaction in flight, tracks the AW and W handshakes independently, and returns the read data and response code through a registered response port.

## Interface

- ADDR_W, 12, AXI address width
- DATA_W, 32, AXI data width (multiple of 8); STRB_W = DATA_W/8
- aclk  in  1  single clock, all logic on rising edge
- aresetn  in  1  asynchronous assert, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata / cmd_wstrb  in  DATA_W / STRB_W  write data and byte strobes (ignored for reads)
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  captured bresp or rresp
- busy  out  1  high whenever the FSM is not in IDLE
- awaddr, awvalid / awready  out, out / in  ADDR_W, 1 / 1
- wdata, wstrb, wvalid / wready  out, out, out / in  DATA_W, STRB_W, 1 / 1
- bresp, bvalid / bready  in, in / out  2, 1 / 1
- araddr, arvalid / arready  out, out / in  ADDR_W, 1 / 1
- rdata, rresp, rvalid / rready  in, in, in / out  DATA_W, 2, 1 / 1

## Operation

- FSM states: IDLE, WR (AW/W in progress), WB (waiting for B), RA (AR in progress), RD (waiting for R), RSP (response held).
- IDLE: cmd_ready = 1. On a cmd handshake, the block latches the command.
  - Write: goes to WR with awvalid = wvalid = 1.
  - Read: goes to RA with arvalid = 1.
- WR: each of awvalid and wvalid clears on the edge of its own handshake (valid && ready). The two handshakes may land in the same cycle or in either order.
  - Sticky flags aw_done and w_done record completion.
  - When both are done, the block moves to WB. This happens on the edge where the later handshake occurs.
- WB: bready = 1. On the bvalid edge, the block captures bresp into rsp_resp, sets rsp_rdata = 0, and moves to RSP.
- RA: arvalid held until arready. The handshake edge moves the block to RD.
- RD: rready = 1. On the rvalid edge, the block captures rdata and rresp and moves to RSP.
- RSP: rsp_valid = 1 with data held stable. A rsp_ready handshake returns the block to IDLE.
- AXI compliance:
  - A valid is never deasserted before its handshake.
  - addr, data and strb are stable while their valid is high.
  - bready and rready are 0 outside WB and RD.
- Single outstanding transaction: cmd_ready = 0 in every state except IDLE, so no new command is accepted until the previous response is consumed.
- SLVERR/DECERR responses are passed through unchanged. The block does not retry.

## Timing

- Reset (async, immediate) drives:
  - cmd_ready = 0 while aresetn is low, then 1 in IDLE.
  - All AXI valids and readys = 0.
  - All address, data and strb outputs = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0, rsp_write = 0, busy = 0.
- All outputs are registered or decoded directly from the state. There is no combinational path from any AXI input to any AXI output.
- Cmd handshake at edge E0: the AXI valid(s) are high in the cycle after E0.
- Zero-wait responder, write:
  - AW and W handshake at E1; bready is high after E1.
  - B handshake at E2 at the earliest; rsp_valid is high after E2.
  - Minimum command-to-response is 3 cycles.
- Zero-wait responder, read: AR handshake at E1, R handshake at E2, rsp_valid after E2.
- rsp_valid held with rsp_ready low: the response stays stable for an unbounded time and the AXI side stays idle.
- rsp_ready high in the first RSP cycle: the block returns to IDLE on that edge, so cmd_ready is back one cycle later. Back-to-back commands therefore have a 1-cycle IDLE gap.
- Reset mid-transaction: all state and outputs return to reset values immediately. Any pending response is discarded. The responder is reset by the same aresetn.

## Test plan

- Read of VERSION, zero-wait responder: cmd read @0x02C -> rsp_rdata = 0x00010000, rsp_resp = 0. rsp_valid rises exactly 3 cycles after the cmd handshake edge.
- Write then read SCRATCH @0x030:
  - Write 0xA5A55A5A with strb 0xF, then read -> 0xA5A55A5A.
  - Write 0x00110000 with strb 0b0100, then read -> 0xA511 5A5A.
- Skewed write handshakes, with a responder that holds wready low 4 cycles after awready:
  - awvalid drops after its own handshake while wvalid stays high.
  - Single B; write lands correctly.
  - Repeat with the order reversed (W first).
- Backpressure:
  - Responder delays arready 3 cycles and rvalid 5 cycles; TB holds rsp_ready low 6 cycles.
  - Required: arvalid stable, araddr stable, cmd_ready = 0 throughout, response unchanged until consumed.
- Error pass-through: responder returns bresp = 2'b10 on a write and rresp = 2'b11 on a read -> rsp_resp equals those codes; the block returns to IDLE.
- Reset mid-write: aresetn driven low while awvalid = 1 -> awvalid, wvalid, busy and rsp_valid are 0 in the same cycle. After release, a read @0x02C completes normally.
